pt_mem_responder: RTL and testbench

- Read-side slave for the Mem_ift read channel. It answers the single-outstanding read requests issued by the page-table-walk unit behind the TLB.
- Each request returns one 64-bit word (a PTE) from a word-addressed backing RAM, after a programmable latency.
- A side load port preloads page tables.
- The block serves as the memory end of the TLB/TMU subsystem in simulation and in FPGA bring-up.

---
 rtl/pt_mem_pkg.sv | 15 +
 rtl/pt_mem_ram.sv | 25 ++
 rtl/pt_mem_responder.sv | 137 +++++++++++++
 tb/tb_pt_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_mem_pkg.sv
// pt_mem_pkg: shared types and constants for the page-table memory responder.
package pt_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned PTE_BYTES  = 8;
  localparam int unsigned WORD_SHIFT = 3;

  typedef logic [63:0] pte_t;

endpackage

// File: rtl/pt_mem_ram.sv
// pt_mem_ram: single-clock DEPTH x DATA_WIDTH RAM, one synchronous read port
// and one write port. A read and a write to the same word on the same edge
// return the old contents.
module pt_mem_ram #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read share the edge; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pt_mem_responder.sv
// pt_mem_responder: read-side slave of the Mem_ift read channel. Answers one
// outstanding PTE read at a time from a word-addressed backing RAM after a
// programmable latency. A side load port preloads the RAM.
// Optional macro PT_MEM_RANDOM_LATENCY_EN adds 0..3 LFSR-driven extra cycles
// of latency per request.
module pt_mem_responder
  import pt_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           DEPTH      = 1024,
  parameter int unsigned           LATENCY    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ren_mem,
  input  logic [ADDR_WIDTH-1:0]    raddr_mem,
  output logic [DATA_WIDTH-1:0]    rdata_mem,
  output logic                     rvalid_mem,
  output logic                     rerr_mem,
  output logic                     busy,
  input  logic                     wen_load,
  input  logic [$clog2(DEPTH)-1:0] waddr_load,
  input  logic [DATA_WIDTH-1:0]    wdata_load
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 5;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic              zero_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_err;
  logic [CNT_W-1:0]      eff_lat;
  logic                  sample;
  logic                  sample_err;
  logic [IDX_W-1:0]      ram_raddr;
  pte_t                  ram_q;

`ifdef PT_MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying extra latency.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // Address decode, range/alignment check and RAM read-port steering.
  always_comb begin
    offset     = raddr_mem - BASE_ADDR;
    word_idx   = offset >> WORD_SHIFT;
    req_err    = (raddr_mem < BASE_ADDR)
              || ((raddr_mem & ADDR_WIDTH'(PTE_BYTES - 1)) != '0)
              || (word_idx >= ADDR_WIDTH'(DEPTH));
    sample     = ((state == IDLE) && ren_mem && (eff_lat == CNT_W'(1)))
              || ((state == WAIT) && (cnt == CNT_W'(1)));
    sample_err = (state == IDLE) ? req_err : err_q;
    ram_raddr  = (state == IDLE) ? word_idx[IDX_W-1:0] : idx_q;
  end

  pt_mem_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wen_load),
    .waddr (waddr_load),
    .wdata (wdata_load),
    .re    (sample),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // RAM output register doubles as the data holding register; zero_q forces
  // the reset value and error responses to read as zero without a second copy.
  assign rdata_mem = zero_q ? '0 : ram_q;

  // Request FSM: accept in IDLE, count down in WAIT, pulse the response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      zero_q     <= 1'b1;
      rvalid_mem <= 1'b0;
      rerr_mem   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rvalid_mem <= 1'b0;
      rerr_mem   <= 1'b0;
      if (sample) zero_q <= sample_err;
      unique case (state)
        IDLE: begin
          if (ren_mem) begin
            idx_q <= word_idx[IDX_W-1:0];
            err_q <= req_err;
            cnt   <= eff_lat - CNT_W'(1);
            busy  <= 1'b1;
            if (eff_lat == CNT_W'(1)) begin
              state      <= RESP;
              rvalid_mem <= 1'b1;
              rerr_mem   <= req_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            rvalid_mem <= 1'b1;
            rerr_mem   <= err_q;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_mem_responder.sv
// tb_pt_mem_responder: self-checking bench with a timeline-level reference model.
module tb_pt_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned L     = 4;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren_mem = 1'b0;
  logic [63:0] raddr_mem = '0;
  logic [63:0] rdata_mem;
  logic        rvalid_mem;
  logic        rerr_mem;
  logic        busy;
  logic        wen_load = 1'b0;
  logic [9:0]  waddr_load = '0;
  logic [63:0] wdata_load = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          rand_loads = 1'b0;

  pt_mem_responder #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .DEPTH      (DEPTH),
    .LATENCY    (L),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ren_mem    (ren_mem),
    .raddr_mem  (raddr_mem),
    .rdata_mem  (rdata_mem),
    .rvalid_mem (rvalid_mem),
    .rerr_mem   (rerr_mem),
    .busy       (busy),
    .wen_load   (wen_load),
    .waddr_load (waddr_load),
    .wdata_load (wdata_load)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (edge-indexed timeline) ----------------
  logic [63:0] mem_m [DEPTH];
  int unsigned k = 0, k0 = 0, lat_eff = L;
  bit          pend = 1'b0, model_ok = 1'b0;
  logic [63:0] pend_addr;
  logic [63:0] exp_rdata = '0;
  bit          exp_rvalid = 1'b0, exp_rerr = 1'b0, exp_busy = 1'b0;
`ifdef PT_MEM_RANDOM_LATENCY_EN
  logic [7:0]  m_lfsr = 8'hA5;
`endif

  always @(posedge clk) begin
    bit          e;
    logic [63:0] idx;
    k++;
    if (rst) begin
      pend = 1'b0; exp_rvalid = 1'b0; exp_rerr = 1'b0; exp_busy = 1'b0;
      exp_rdata = '0; model_ok = 1'b1;
`ifdef PT_MEM_RANDOM_LATENCY_EN
      m_lfsr = 8'hA5;
`endif
    end else begin
      exp_rvalid = 1'b0; exp_rerr = 1'b0;
      if (pend && k == k0 + lat_eff) pend = 1'b0;
      else if (!pend && ren_mem) begin
        pend = 1'b1; k0 = k; pend_addr = raddr_mem;
`ifdef PT_MEM_RANDOM_LATENCY_EN
        lat_eff = L + int'(m_lfsr[1:0]);
`else
        lat_eff = L;
`endif
      end
      if (pend && k == k0 + lat_eff - 1) begin
        idx = (pend_addr - BASE) / 8;
        e = (pend_addr < BASE) || (pend_addr % 8 != 0) || (pend_addr >= BASE && idx >= DEPTH);
        exp_rvalid = 1'b1;
        exp_rerr   = e;
        exp_rdata  = e ? 64'd0 : mem_m[idx[9:0]];
      end
      exp_busy = pend;
`ifdef PT_MEM_RANDOM_LATENCY_EN
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    end
    if (wen_load) mem_m[waddr_load] = wdata_load;
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("rvalid", 64'(rvalid_mem), 64'(exp_rvalid));
      check("rerr",   64'(rerr_mem),   64'(exp_rerr));
      check("busy",   64'(busy),       64'(exp_busy));
      check("rdata",  rdata_mem,       exp_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_read(input logic [63:0] a, input bit drop,
                         output int lat, output logic [63:0] d, output bit e);
    ren_mem = 1'b1; raddr_mem = a; lat = 0;
    do begin
      @(negedge clk); lat++;
      if (rand_loads) begin
        wen_load   = ($urandom % 3) == 0;
        waddr_load = 10'($urandom % 16);
        wdata_load = {$urandom, $urandom};
      end else wen_load = 1'b0;
    end while (!rvalid_mem && lat < 40);
    if (!rvalid_mem) check("read_timeout", 64'd0, 64'd1);
    d = rdata_mem; e = rerr_mem;
    if (drop) ren_mem = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] d;
    bit          e;
    int unsigned cnt;
    logic [63:0] a;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rvalid", 64'(rvalid_mem), 64'd0);
    check("reset_busy",   64'(busy),       64'd0);
    check("reset_rdata",  rdata_mem,       64'd0);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      wen_load = 1'b1; waddr_load = 10'(i);
      wdata_load = (i == 5) ? 64'h0000_0000_2000_1C01 : {$urandom, $urandom};
      @(negedge clk);
    end
    wen_load = 1'b0;
    @(negedge clk);

    // Basic read of word 5.
    do_read(64'h8000_0028, 1'b1, lat, d, e);
`ifndef PT_MEM_RANDOM_LATENCY_EN
    check("basic_latency", 64'(lat), 64'd4);
`endif
    check("basic_data", d, 64'h2000_1C01);
    check("basic_err",  64'(e), 64'd0);
    @(negedge clk);
    check("basic_pulse_end", 64'(rvalid_mem), 64'd0);

    // Error and boundary addresses.
    do_read(64'h8000_0004, 1'b1, lat, d, e); @(negedge clk);
    check("misalign_err",  64'(e), 64'd1);
    check("misalign_data", d, 64'd0);
    do_read(64'h7FFF_FFF8, 1'b1, lat, d, e); @(negedge clk);
    check("below_base_err", 64'(e), 64'd1);
    do_read(64'h8000_2000, 1'b1, lat, d, e); @(negedge clk);
    check("index_1024_err", 64'(e), 64'd1);
    do_read(64'h8000_1FF8, 1'b1, lat, d, e); @(negedge clk);
    check("index_1023_err", 64'(e), 64'd0);

`ifndef PT_MEM_RANDOM_LATENCY_EN
    // Load to word 5 in the sample cycle T+3 returns the old data.
    ren_mem = 1'b1; raddr_mem = 64'h8000_0028;
    repeat (3) @(negedge clk);
    wen_load = 1'b1; waddr_load = 10'd5; wdata_load = 64'hAAAA;
    @(negedge clk);
    wen_load = 1'b0;
    check("rbw_rvalid", 64'(rvalid_mem), 64'd1);
    check("rbw_old_data", rdata_mem, 64'h2000_1C01);
    ren_mem = 1'b0;
    @(negedge clk);
`else
    wen_load = 1'b1; waddr_load = 10'd5; wdata_load = 64'hAAAA;
    @(negedge clk);
    wen_load = 1'b0;
`endif
    do_read(64'h8000_0028, 1'b1, lat, d, e); @(negedge clk);
    check("reread_new_data", d, 64'hAAAA);

    // Back-to-back: ren held through RESP, new address presented in IDLE.
    do_read(64'h8000_0010, 1'b0, lat, d, e);
    do_read(64'h8000_0028, 1'b1, lat, d, e);
`ifndef PT_MEM_RANDOM_LATENCY_EN
    check("b2b_latency", 64'(lat), 64'd5);
`endif
    check("b2b_data", d, 64'hAAAA);
    @(negedge clk);

    // ren pulses during WAIT are ignored: one response only.
    ren_mem = 1'b1; raddr_mem = 64'h8000_0018; cnt = 0;
    for (int unsigned i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rvalid_mem) cnt++;
      ren_mem = (i == 2);
    end
    check("wait_pulse_one_rvalid", 64'(cnt), 64'd1);

    // Reset asserted at T+2 aborts the request.
    ren_mem = 1'b1; raddr_mem = 64'h8000_0028;
    repeat (2) @(negedge clk);
    rst = 1'b1; ren_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid_mem) cnt++;
    end
    check("abort_no_rvalid", 64'(cnt), 64'd0);
    do_read(64'h8000_0028, 1'b1, lat, d, e); @(negedge clk);
`ifndef PT_MEM_RANDOM_LATENCY_EN
    check("after_abort_latency", 64'(lat), 64'd4);
`endif
    check("after_abort_data", d, 64'hAAAA);

    // Randomized traffic with concurrent loads, checked by the model.
    rand_loads = 1'b1;
    for (int unsigned n = 0; n < 150; n++) begin
      case ($urandom % 10)
        0:       a = BASE + 64'($urandom % 16) * 8 + 64'($urandom_range(1, 7));
        1:       a = BASE - 64'($urandom_range(1, 4)) * 8;
        2:       a = BASE + 64'(DEPTH) * 8 + 64'($urandom % 4) * 8;
        3:       a = BASE + 64'($urandom % DEPTH) * 8;
        default: a = BASE + 64'($urandom % 16) * 8;
      endcase
      do_read(a, ($urandom % 4) != 0, lat, d, e);
      if (!ren_mem) repeat ($urandom % 3) @(negedge clk);
    end
    rand_loads = 1'b0;
    wen_load = 1'b0; ren_mem = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
